// File: rtl/subservient_sram_arb_pkg.sv
// Shared types and constants for the subservient SRAM arbiter.
package subservient_sram_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } state_e;

  localparam int unsigned REQ_CORE = 0;
  localparam int unsigned REQ_HOST = 1;

  localparam int unsigned STATS_W  = 16;
  // Wide enough for any maxlock in 1..255.
  localparam int unsigned LOCK_CNT_W = 8;

endpackage

// File: rtl/subservient_sram_arb_sel.sv
// Two-way round-robin select with lock override; produces a one-hot grant.
module subservient_sram_arb_sel
  import subservient_sram_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       ptr_i,     // preferred side when both request
  input  logic       locked_i,  // lock state active
  input  logic       owner_i,   // lock owner
  input  logic       sat_i,     // lock counter at its limit
  output logic [1:0] gnt_o
);

  logic other_req;
  logic own_req;

  assign other_req = owner_i ? req_i[REQ_CORE] : req_i[REQ_HOST];
  assign own_req   = owner_i ? req_i[REQ_HOST] : req_i[REQ_CORE];

  // Pick the winner; a saturated lock with a waiting peer grants nobody this cycle.
  always_comb begin
    gnt_o = 2'b00;
    if (!locked_i) begin
      if (req_i == 2'b11) begin
        gnt_o = ptr_i ? 2'b10 : 2'b01;
      end else begin
        gnt_o = req_i;
      end
    end else if (!(sat_i && other_req) && own_req) begin
      gnt_o = owner_i ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/subservient_sram_arb.sv
// Arbiter sharing the byte-wide subservient SRAM between core and host.
// Optional grant statistics output enabled by SUBSERVIENT_SRAM_ARB_STATS_EN.
module subservient_sram_arb
  import subservient_sram_arb_pkg::*;
#(
  parameter int unsigned memsize = 512,
  parameter int unsigned aw      = $clog2(memsize),
  parameter int unsigned maxlock = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [1:0]    i_req,
  input  logic [1:0]    i_we,
  input  logic [aw-1:0] i_addr0,
  input  logic [aw-1:0] i_addr1,
  input  logic [7:0]    i_wdata0,
  input  logic [7:0]    i_wdata1,
  input  logic [1:0]    i_lock,
  output logic [1:0]    o_gnt,
  output logic [1:0]    o_rvalid,
  output logic [7:0]    o_rdata,
  output logic [aw-1:0] o_sram_waddr,
  output logic [7:0]    o_sram_wdata,
  output logic          o_sram_wen,
  output logic [aw-1:0] o_sram_raddr,
  input  logic [7:0]    i_sram_rdata
`ifdef SUBSERVIENT_SRAM_ARB_STATS_EN
  ,
  output logic [31:0]   o_stats
`endif
);

  localparam logic [LOCK_CNT_W-1:0] MaxLock = LOCK_CNT_W'(maxlock);

  state_e                  state_q;
  logic                    owner_q;
  logic                    ptr_q;
  logic [LOCK_CNT_W-1:0]   cnt_q;
  logic [1:0]              rvalid_q;
  logic [aw-1:0]           addr_q;
  logic [7:0]              wdata_q;

  logic [1:0]              sel_gnt;
  logic [1:0]              gnt;
  logic                    any_gnt;
  logic                    gidx;
  logic                    glock;
  logic                    gwe;
  logic [aw-1:0]           gaddr;
  logic [7:0]              gwdata;
  logic                    sat;
  logic                    force_ret;

  assign sat       = (cnt_q == MaxLock);
  assign force_ret = (state_q == LOCK) && sat &&
                     (owner_q ? i_req[REQ_CORE] : i_req[REQ_HOST]);

  subservient_sram_arb_sel u_sel (
    .req_i    (i_req),
    .ptr_i    (ptr_q),
    .locked_i (state_q == LOCK),
    .owner_i  (owner_q),
    .sat_i    (sat),
    .gnt_o    (sel_gnt)
  );

  // Grant is combinational but held off while reset is asserted.
  assign gnt     = i_rst ? 2'b00 : sel_gnt;
  assign any_gnt = |gnt;
  assign gidx    = gnt[REQ_HOST];
  assign glock   = gidx ? i_lock[REQ_HOST]  : i_lock[REQ_CORE];
  assign gwe     = gidx ? i_we[REQ_HOST]    : i_we[REQ_CORE];
  assign gaddr   = gidx ? i_addr1           : i_addr0;
  assign gwdata  = gidx ? i_wdata1          : i_wdata0;

  assign o_gnt        = gnt;
  assign o_sram_wen   = any_gnt & gwe;
  // Idle cycles replay the last granted address/data so the macro pins stay quiet.
  assign o_sram_waddr = any_gnt ? gaddr  : addr_q;
  assign o_sram_raddr = any_gnt ? gaddr  : addr_q;
  assign o_sram_wdata = any_gnt ? gwdata : wdata_q;
  assign o_rvalid     = rvalid_q;
  assign o_rdata      = i_sram_rdata;

  // Arbitration FSM, lock counter, round-robin pointer and read-valid pipe.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ARB;
      owner_q  <= 1'b0;
      ptr_q    <= 1'b0;
      cnt_q    <= '0;
      rvalid_q <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      rvalid_q <= gnt & ~i_we;
      if (any_gnt) begin
        addr_q  <= gaddr;
        wdata_q <= gwdata;
      end
      unique case (state_q)
        ARB: begin
          if (any_gnt) begin
            ptr_q <= ~gidx;
            if (glock) begin
              state_q <= LOCK;
              owner_q <= gidx;
              cnt_q   <= LOCK_CNT_W'(1);
            end
          end
        end
        LOCK: begin
          if (force_ret) begin
            state_q <= ARB;
            ptr_q   <= ~owner_q;
            cnt_q   <= '0;
          end else if (any_gnt) begin
            if (glock) begin
              if (!sat) cnt_q <= cnt_q + LOCK_CNT_W'(1);
            end else begin
              state_q <= ARB;
              ptr_q   <= ~owner_q;
              cnt_q   <= '0;
            end
          end
        end
        default: state_q <= ARB;
      endcase
    end
  end

`ifdef SUBSERVIENT_SRAM_ARB_STATS_EN
  logic [STATS_W-1:0] stat_core_q;
  logic [STATS_W-1:0] stat_host_q;

  // Saturating per-requester grant counters.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stat_core_q <= '0;
      stat_host_q <= '0;
    end else begin
      if (gnt[REQ_CORE] && (stat_core_q != '1)) stat_core_q <= stat_core_q + 1'b1;
      if (gnt[REQ_HOST] && (stat_host_q != '1)) stat_host_q <= stat_host_q + 1'b1;
    end
  end

  assign o_stats = {stat_host_q, stat_core_q};
`endif

endmodule

// File: tb/tb_subservient_sram_arb.sv
// Self-checking bench for subservient_sram_arb (scoreboarded read returns).
module tb_subservient_sram_arb;

  localparam int unsigned AW = 9;

  typedef struct {
    logic [1:0] rv;
    logic [7:0] rd;
  } exp_t;

  logic          clk;
  logic          rst;
  logic [1:0]    req;
  logic [1:0]    we;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [7:0]    wdata0;
  logic [7:0]    wdata1;
  logic [1:0]    lock;
  logic [1:0]    gnt;
  logic [1:0]    rvalid;
  logic [7:0]    rdata;
  logic [AW-1:0] sram_waddr;
  logic [7:0]    sram_wdata;
  logic          sram_wen;
  logic [AW-1:0] sram_raddr;
  logic [7:0]    sram_rdata;
`ifdef SUBSERVIENT_SRAM_ARB_STATS_EN
  logic [31:0]   stats;
`endif

  int   n_checks;
  int   n_fail;
  exp_t sb[$];

  subservient_sram_arb #(
    .memsize (512),
    .maxlock (16)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req        (req),
    .i_we         (we),
    .i_addr0      (addr0),
    .i_addr1      (addr1),
    .i_wdata0     (wdata0),
    .i_wdata1     (wdata1),
    .i_lock       (lock),
    .o_gnt        (gnt),
    .o_rvalid     (rvalid),
    .o_rdata      (rdata),
    .o_sram_waddr (sram_waddr),
    .o_sram_wdata (sram_wdata),
    .o_sram_wen   (sram_wen),
    .o_sram_raddr (sram_raddr),
    .i_sram_rdata (sram_rdata)
`ifdef SUBSERVIENT_SRAM_ARB_STATS_EN
    ,
    .o_stats      (stats)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    req = 2'b00; we = 2'b00; lock = 2'b00;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    idle_inputs();
    sram_rdata = 8'h00;
    rst = 1'b1;
    @(posedge clk); #4;
    n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL rst_gnt got %b want 00", gnt); end
    n_checks++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL rst_rvalid got %b want 00", rvalid); end
    n_checks++; if (sram_wen !== 1'b0) begin n_fail++; $display("FAIL rst_wen got %b want 0", sram_wen); end
    n_checks++; if (sram_waddr !== '0 || sram_raddr !== '0) begin
      n_fail++; $display("FAIL rst_addr got w=%h r=%h want 0", sram_waddr, sram_raddr);
    end
    n_checks++; if (sram_wdata !== 8'h00) begin n_fail++; $display("FAIL rst_wdata got %h want 00", sram_wdata); end
`ifdef SUBSERVIENT_SRAM_ARB_STATS_EN
    n_checks++; if (stats !== 32'h0) begin n_fail++; $display("FAIL rst_stats got %h want 0", stats); end
`endif
    #1 rst = 1'b0;
  endtask

  task automatic test_core_read();
    exp_t e;
    do_reset();
    @(posedge clk); #1;
    req = 2'b01; we = 2'b00; addr0 = 9'h010; sram_rdata = 8'hA5;
    #4;
    n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL cr_gnt got %b want 01", gnt); end
    n_checks++; if (sram_raddr !== 9'h010) begin n_fail++; $display("FAIL cr_raddr got %h want 010", sram_raddr); end
    n_checks++; if (sram_wen !== 1'b0) begin n_fail++; $display("FAIL cr_wen got %b want 0", sram_wen); end
    e.rv = 2'b01; e.rd = 8'hA5; sb.push_back(e);
    @(posedge clk); #1;
    req = 2'b00;
    #4;
    e = sb.pop_front();
    n_checks++; if (rvalid !== e.rv) begin n_fail++; $display("FAIL cr_rvalid got %b want %b", rvalid, e.rv); end
    n_checks++; if (rdata !== e.rd) begin n_fail++; $display("FAIL cr_rdata got %h want %h", rdata, e.rd); end
    n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL cr_idle_gnt got %b want 00", gnt); end
  endtask

  task automatic test_alternate();
    exp_t       e;
    logic [1:0] exp_g;
    do_reset();
    sram_rdata = 8'h3C;
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); #1;
      if (c < 8) begin
        req = 2'b11; we = 2'b01; lock = 2'b00;
        addr0 = 9'h000; wdata0 = 8'h5A; addr1 = 9'h1FF;
      end else begin
        req = 2'b00;
      end
      #4;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if (rvalid !== e.rv) begin n_fail++; $display("FAIL alt_rvalid c=%0d got %b want %b", c, rvalid, e.rv); end
        if (e.rv != 2'b00) begin
          n_checks++;
          if (rdata !== e.rd) begin n_fail++; $display("FAIL alt_rdata c=%0d got %h want %h", c, rdata, e.rd); end
        end
      end
      exp_g = (c >= 8) ? 2'b00 : ((c % 2 == 0) ? 2'b01 : 2'b10);
      e.rv = (exp_g == 2'b10) ? 2'b10 : 2'b00; e.rd = 8'h3C; sb.push_back(e);
      n_checks++; if (gnt !== exp_g) begin n_fail++; $display("FAIL alt_gnt c=%0d got %b want %b", c, gnt, exp_g); end
      n_checks++; if (sram_wen !== (exp_g == 2'b01)) begin
        n_fail++; $display("FAIL alt_wen c=%0d got %b want %b", c, sram_wen, exp_g == 2'b01);
      end
      if (exp_g == 2'b01) begin
        n_checks++; if (sram_waddr !== 9'h000 || sram_wdata !== 8'h5A) begin
          n_fail++; $display("FAIL alt_wr c=%0d got %h/%h want 000/5a", c, sram_waddr, sram_wdata);
        end
      end else if (exp_g == 2'b10) begin
        n_checks++; if (sram_raddr !== 9'h1FF) begin
          n_fail++; $display("FAIL alt_raddr c=%0d got %h want 1ff", c, sram_raddr);
        end
      end
    end
  endtask

  task automatic test_lock_max();
    exp_t       e;
    logic [1:0] exp_g;
    int         hdone;
    bit         cdone;
    do_reset();
    hdone = 0; cdone = 1'b0;
    sram_rdata = 8'h77;
    for (int c = 0; c <= 22; c++) begin
      @(posedge clk); #1;
      req[1]  = (hdone < 20);
      we[1]   = 1'b1;
      addr1   = AW'(9'h100 + hdone);
      wdata1  = 8'(hdone);
      lock[1] = (hdone < 19);
      req[0]  = (c >= 1) && !cdone;
      we[0]   = 1'b0;
      lock[0] = 1'b0;
      addr0   = 9'h020;
      #4;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if (rvalid !== e.rv) begin n_fail++; $display("FAIL lk_rvalid c=%0d got %b want %b", c, rvalid, e.rv); end
        if (e.rv != 2'b00) begin
          n_checks++;
          if (rdata !== e.rd) begin n_fail++; $display("FAIL lk_rdata c=%0d got %h want %h", c, rdata, e.rd); end
        end
      end
      if (c <= 15)      exp_g = 2'b10;
      else if (c == 16) exp_g = 2'b00;
      else if (c == 17) exp_g = 2'b01;
      else if (c <= 21) exp_g = 2'b10;
      else              exp_g = 2'b00;
      e.rv = (exp_g == 2'b01) ? 2'b01 : 2'b00; e.rd = 8'h77; sb.push_back(e);
      n_checks++; if (gnt !== exp_g) begin n_fail++; $display("FAIL lk_gnt c=%0d got %b want %b", c, gnt, exp_g); end
      if (exp_g == 2'b10) begin
        n_checks++;
        if (sram_wen !== 1'b1 || sram_waddr !== AW'(9'h100 + hdone) || sram_wdata !== 8'(hdone)) begin
          n_fail++; $display("FAIL lk_hwr c=%0d got wen=%b a=%h d=%h want 1/%h/%h", c, sram_wen,
                             sram_waddr, sram_wdata, AW'(9'h100 + hdone), 8'(hdone));
        end
        hdone++;
      end else if (exp_g == 2'b01) begin
        n_checks++; if (sram_wen !== 1'b0 || sram_raddr !== 9'h020) begin
          n_fail++; $display("FAIL lk_crd c=%0d got wen=%b a=%h want 0/020", c, sram_wen, sram_raddr);
        end
        cdone = 1'b1;
      end
    end
  endtask

  task automatic test_lock_idle();
    exp_t       e;
    logic [1:0] exp_g;
    do_reset();
    sram_rdata = 8'hC3;
    for (int c = 0; c <= 8; c++) begin
      @(posedge clk); #1;
      req[1]  = (c == 0) || (c == 6);
      we[1]   = 1'b1;
      lock[1] = (c == 0);
      addr1   = 9'h0AA;
      req[0]  = (c >= 1) && (c <= 7);
      we[0]   = 1'b0;
      lock[0] = 1'b0;
      addr0   = 9'h055;
      #4;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if (rvalid !== e.rv) begin n_fail++; $display("FAIL li_rvalid c=%0d got %b want %b", c, rvalid, e.rv); end
        if (e.rv != 2'b00) begin
          n_checks++;
          if (rdata !== e.rd) begin n_fail++; $display("FAIL li_rdata c=%0d got %h want %h", c, rdata, e.rd); end
        end
      end
      if (c == 0 || c == 6) exp_g = 2'b10;
      else if (c == 7)      exp_g = 2'b01;
      else                  exp_g = 2'b00;
      e.rv = (exp_g == 2'b01) ? 2'b01 : 2'b00; e.rd = 8'hC3; sb.push_back(e);
      n_checks++; if (gnt !== exp_g) begin n_fail++; $display("FAIL li_gnt c=%0d got %b want %b", c, gnt, exp_g); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    sram_rdata = 8'h99;
    @(posedge clk); #1;
    req = 2'b10; we = 2'b00; lock = 2'b10; addr1 = 9'h1FF;
    #4;
    n_checks++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL rm_gnt got %b want 10", gnt); end
    @(posedge clk); #1;
    rst = 1'b1;
    req = 2'b11; we = 2'b00; lock = 2'b00; addr0 = 9'h011;
    #2;
    n_checks++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL rm_rvalid got %b want 00", rvalid); end
    n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL rm_gnt_rst got %b want 00", gnt); end
    @(posedge clk); #1;
    rst = 1'b0;
    #3;
    n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL rm_post_gnt got %b want 01", gnt); end
    @(posedge clk); #4;
    n_checks++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL rm_post_gnt2 got %b want 10", gnt); end
    n_checks++; if (rvalid !== 2'b01) begin n_fail++; $display("FAIL rm_post_rvalid got %b want 01", rvalid); end
    idle_inputs();
  endtask

`ifdef SUBSERVIENT_SRAM_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      req = 2'b10; we = 2'b10; addr1 = AW'(c);
    end
    @(posedge clk); #1;
    req = 2'b01; we = 2'b01;
    repeat (70000) @(posedge clk);
    #1 req = 2'b00;
    #4;
    n_checks++; if (stats[15:0] !== 16'hFFFF) begin
      n_fail++; $display("FAIL st_core got %h want ffff", stats[15:0]);
    end
    n_checks++; if (stats[31:16] !== 16'd3) begin
      n_fail++; $display("FAIL st_host got %h want 0003", stats[31:16]);
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    idle_inputs();
    sram_rdata = 8'h00;
    test_reset();
    test_core_read();
    test_alternate();
    test_lock_max();
    test_lock_idle();
    test_reset_mid();
`ifdef SUBSERVIENT_SRAM_ARB_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
